cmd_uart_wrapper: RTL and testbench

CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

---
 rtl/cmd_uart_wrapper.sv | 185 ++++++++++++++++++
 tb/tb_cmd_uart_wrapper.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_wrapper.sv
// UART command front end: receives two-byte commands over RX (8N1) and
// transmits single response bytes over TX. The RX and TX paths run independently.
module cmd_uart_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic { RX_IDLE, RX_RECV } rx_state_t;
  typedef enum logic { TX_IDLE, TX_XMIT } tx_state_t;
  typedef enum logic { WAIT_HI, WAIT_LO } asm_state_t;

  // ---------------------------------------------------------------------------
  // RX synchronizer plus one extra stage for falling-edge detection
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its source, making this a true shift chain.
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          rx_rdy;
  logic          rx_start;

  assign rx_start = (rx_state == RX_IDLE) && rx_prev && !rx_sync;

  // ---------------------------------------------------------------------------
  // RX engine: first sample mid start bit, then one sample per bit period.
  // Sample 0 is the start bit, samples 1..8 are data (LSB first), 9 is the stop bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_start) begin
            rx_state <= RX_RECV;
            rx_cnt   <= HALF_CNT;
            rx_bits  <= '0;
          end
        end
        RX_RECV: begin
          if (rx_cnt == '0) begin
            rx_cnt <= FULL_CNT;
            if (rx_bits == 4'd9) begin
              // Stop bit is sampled for timing only; its value is not checked.
              rx_state <= RX_IDLE;
              rx_rdy   <= 1'b1;
            end else begin
              if (rx_bits != 4'd0)
                rx_shift <= {rx_sync, rx_shift[7:1]};
              rx_bits <= rx_bits + 4'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte assembler: pairs received bytes into {high, low} commands.
  // ---------------------------------------------------------------------------
  asm_state_t asm_state;
  logic [7:0] hi_byte;
  logic       cmd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= WAIT_HI;
      hi_byte   <= '0;
      cmd       <= '0;
      cmd_done  <= 1'b0;
      cmd_rdy   <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (asm_state)
        WAIT_HI: begin
          if (rx_rdy) begin
            hi_byte   <= rx_shift;
            asm_state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (rx_rdy) begin
            cmd       <= {hi_byte, rx_shift};
            cmd_done  <= 1'b1;
            asm_state <= WAIT_HI;
          end
        end
        default: asm_state <= WAIT_HI;
      endcase

      // A completing command beats a simultaneous acknowledge.
      if (cmd_done)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (rx_start && asm_state == WAIT_HI))
        cmd_rdy <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX engine: 10-bit frame shifted out LSB first; ones shift in behind it so
  // the line rests high once the frame is gone.
  // ---------------------------------------------------------------------------
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic [9:0]    tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      tx_shift  <= '1;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_shift <= {1'b1, resp, 1'b0};
            tx_cnt   <= FULL_CNT;
            tx_bits  <= '0;
            tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == '0) begin
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_cnt   <= FULL_CNT;
            if (tx_bits == 4'd9) begin
              tx_state  <= TX_IDLE;
              resp_sent <= 1'b1;
            end else begin
              tx_bits <= tx_bits + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign TX = tx_shift[0];

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Self-checking bench for cmd_uart_wrapper: directed scenarios plus randomized
// commands/responses compared against a byte-level command and frame model.
module tb_cmd_uart_wrapper;

  localparam int BAUD_DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int n_vectors = 0;
  int n_miscompares = 0;
  int n_sent = 0;

  // Reference model state: what the command port should show.
  logic [15:0] exp_cmd;
  logic        exp_rdy;
  logic        have_hi;
  logic [7:0]  hi_byte;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  cmd_uart_wrapper #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (rx_line),
    .TX         (tx),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  always @(posedge clk) if (resp_sent === 1'b1) n_sent++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    have_hi = 1'b0;
    hi_byte = 8'h00;
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
  endfunction

  function automatic void model_start();
    if (!have_hi) exp_rdy = 1'b0;
  endfunction

  function automatic void model_done(input logic [7:0] b);
    if (have_hi) begin
      exp_cmd = {hi_byte, b};
      exp_rdy = 1'b1;
      have_hi = 1'b0;
    end else begin
      hi_byte = b;
      have_hi = 1'b1;
    end
  endfunction

  task automatic check_cmd(input string tag);
    check({tag, "_cmd"}, cmd, exp_cmd);
    check({tag, "_rdy"}, cmd_rdy, exp_rdy);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) rx_drv = 1'b0;
    model_start();
    repeat (BAUD_DIV / 2) @(negedge clk);
    check_cmd("rx_start");
    repeat (BAUD_DIV - BAUD_DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (BAUD_DIV + 4) @(negedge clk);
    model_done(b);
    check_cmd("rx_done");
  endtask

  // Start bit plus a few data bits, then the line is released.
  task automatic send_partial(input logic [7:0] b);
    @(negedge clk) rx_drv = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_drv = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk) rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_rdy", cmd_rdy, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic clr_pulse();
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
  endtask

  task automatic pulse_send(input logic [7:0] b);
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk) send_resp = 1'b0;
  endtask

  // Expects one frame {stop, b, start} on TX, each bit held BAUD_DIV clocks.
  task automatic tx_monitor(input logic [7:0] b);
    logic [9:0] frame;
    int n;
    frame = {1'b1, b, 1'b0};
    n = 0;
    while (tx !== 1'b0 && n < 4 * BAUD_DIV) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      check("tx_start_timeout", tx, 1'b0);
      return;
    end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BAUD_DIV; c++) begin
        check("tx_bit", tx, frame[i]);
        @(negedge clk);
      end
    end
    check("resp_sent_pulse", resp_sent, 1'b1);
    check("tx_idle_after", tx, 1'b1);
    @(negedge clk);
    check("resp_sent_width", resp_sent, 1'b0);
  endtask

  task automatic tx_frame(input logic [7:0] b);
    fork
      tx_monitor(b);
      pulse_send(b);
    join
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int low;
    logic [7:0] b0, b1, r;

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_cmd", cmd, 16'h0000);
    check("reset_rdy", cmd_rdy, 1'b0);
    check("reset_resp_sent", resp_sent, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic command and acknowledge.
    send_byte(8'h70);
    send_byte(8'h40);
    check("cmd_7040", cmd, 16'h7040);
    clr_pulse();
    @(negedge clk);
    check_cmd("after_clr");

    // Response frame with an ignored second request mid-frame.
    s0 = n_sent;
    fork
      tx_monitor(8'hA5);
      begin
        pulse_send(8'hA5);
        repeat (3 * BAUD_DIV) @(negedge clk);
        pulse_send(8'h5A);
      end
    join
    low = 0;
    repeat (4 * BAUD_DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    check("tx_no_second_frame", low, 0);
    check("resp_sent_once", n_sent - s0, 1);

    // New start bit in WAIT_HI drops a pending cmd_rdy.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h00);
    send_byte(8'h01);
    check("cmd_0001", cmd, 16'h0001);

    // Reset between the two bytes of a command.
    send_byte(8'h12);
    do_reset(5);
    send_byte(8'h34);
    send_byte(8'h56);
    check("cmd_3456", cmd, 16'h3456);

    // Reset in the middle of a byte.
    send_byte(8'h9A);
    send_partial(8'hBC);
    do_reset(5);
    repeat (12 * BAUD_DIV) @(negedge clk);
    check_cmd("mid_frame_reset");
    send_byte(8'hDE);
    send_byte(8'hF0);
    check("cmd_def0", cmd, 16'hDEF0);

    // Loopback: TX drives RX, both paths active together.
    loop_en = 1'b1;
    tx_frame(8'hC3);
    repeat (6) @(negedge clk);
    model_start();
    model_done(8'hC3);
    check_cmd("loop_c3");
    tx_frame(8'h3C);
    repeat (6) @(negedge clk);
    model_start();
    model_done(8'h3C);
    check_cmd("loop_3c");
    check("cmd_c33c", cmd, 16'hC33C);
    loop_en = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized commands, overlapping responses and acknowledges.
    for (int k = 0; k < 10; k++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      r  = 8'($urandom);
      if (k % 2 == 1) begin
        fork
          send_byte(b0);
          tx_frame(r);
        join
      end else begin
        send_byte(b0);
      end
      send_byte(b1);
      check("rand_cmd", cmd, {b0, b1});
      if ($urandom_range(0, 1) == 1) begin
        clr_pulse();
        @(negedge clk);
        check_cmd("rand_clr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
